// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, decode and execute.
// The fetch unit takes the master modport; the memory/decode/execute side takes the slave modport.
interface fetch_unit_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          halt;

    modport master (
        output mem_req, mem_addr, ir, ir_pc, ir_valid,
        input  mem_ack, mem_rdata, ir_ready, redirect_valid, redirect_target, halt
    );

    modport slave (
        input  mem_req, mem_addr, ir, ir_pc, ir_valid,
        output mem_ack, mem_rdata, ir_ready, redirect_valid, redirect_target, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory req/ack, IR with valid/ready handoff to decode, redirects.
// Defining FETCH_CNT_EN adds the fetch_cnt output counting instructions accepted by decode.
module fetch_unit #(
    parameter int            AW       = 12,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst_n,
    fetch_unit_if.master bus
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0] fetch_cnt
`endif
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_pc, w_pc_next;
    logic [AW-1:0] r_addr, w_addr_next;
    logic [DW-1:0] r_ir, w_ir_next;
    logic [AW-1:0] r_ir_pc, w_ir_pc_next;
    logic          r_ir_valid, w_ir_valid_next;
    logic          r_flush, w_flush_next;
    logic          w_accept;
    logic [AW-1:0] w_pc_inc;

    assign w_accept = r_ir_valid && bus.ir_ready;
    assign w_pc_inc = r_pc + {{(AW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_addr     <= w_addr_next;
            r_ir       <= w_ir_next;
            r_ir_pc    <= w_ir_pc_next;
            r_ir_valid <= w_ir_valid_next;
            r_flush    <= w_flush_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_addr_next     = r_addr;
        w_ir_next       = r_ir;
        w_ir_pc_next    = r_ir_pc;
        w_ir_valid_next = r_ir_valid;
        w_flush_next    = r_flush;

        case (r_state)
            S_IDLE: begin
                if (bus.redirect_valid) begin
                    w_pc_next = bus.redirect_target;
                end
                if (!bus.halt) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    if (r_flush || bus.redirect_valid) begin
                        // Stale or redirected response: drop it and re-issue at the current pc.
                        w_flush_next = 1'b0;
                        if (bus.redirect_valid) begin
                            w_pc_next = bus.redirect_target;
                        end
                    end else begin
                        w_ir_next       = bus.mem_rdata;
                        w_ir_pc_next    = r_addr;
                        w_ir_valid_next = 1'b1;
                        w_state_next    = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    w_pc_next    = bus.redirect_target;
                    w_flush_next = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    w_pc_next       = bus.redirect_target;
                    w_ir_valid_next = 1'b0;
                    w_state_next    = bus.halt ? S_IDLE : S_REQ;
                end else if (w_accept) begin
                    w_pc_next       = w_pc_inc;
                    w_ir_valid_next = 1'b0;
                    w_state_next    = bus.halt ? S_IDLE : S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // The address seen by memory must not move while a request is outstanding.
        if (!(r_state == S_REQ && !bus.mem_ack)) begin
            w_addr_next = w_pc_next;
        end
    end

    assign bus.mem_req  = (r_state == S_REQ);
    assign bus.mem_addr = r_addr;
    assign bus.ir       = r_ir;
    assign bus.ir_pc    = r_ir_pc;
    assign bus.ir_valid = r_ir_valid;

`ifdef FETCH_CNT_EN
    logic [15:0] r_fetch_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= 16'd0;
        end else if (w_accept) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue holds expected (ir_pc, ir) pairs,
// a monitor pops one per decode acceptance; the stimulus thread also checks bus state per cycle.
module tb_fetch_unit;
    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] ir;
    } exp_t;

    logic clk;
    logic rst_n;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    fetch_unit_if #(.AW(AW), .DW(DW)) bus ();

    fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(12'h000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt (fetch_cnt)
`endif
    );

    exp_t q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_accepts = 0;
    int   ack_delay = 0;
    int   wait_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] instr(input logic [AW-1:0] a);
        return {4'hC, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a);
        exp_t e;
        e.pc = a;
        e.ir = instr(a);
        q.push_back(e);
    endtask

    // Memory: acks after ack_delay wait cycles, data derived from the address.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            bus.mem_rdata = instr(bus.mem_addr);
            bus.mem_ack   = (wait_cnt >= ack_delay);
            if (bus.mem_ack) wait_cnt = 0;
            else             wait_cnt++;
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end
    end

    // Scoreboard monitor: one comparison per instruction accepted by decode.
    always @(negedge clk) begin
        if (rst_n && bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
            exp_t e;
            n_accepts++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_accept: got ir_pc=%0h ir=%0h expected none", bus.ir_pc, bus.ir);
            end else begin
                e = q.pop_front();
                check("acc_ir_pc", 32'(bus.ir_pc), 32'(e.pc));
                check("acc_ir", 32'(bus.ir), 32'(e.ir));
                $display("[TB] accept ir_pc=%03h ir=%04h", bus.ir_pc, bus.ir);
            end
        end
    end

    initial begin
        rst_n               = 1'b0;
        bus.mem_ack         = 1'b0;
        bus.mem_rdata       = '0;
        bus.ir_ready        = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.halt            = 1'b0;

        tick();
        tick();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h000);
        check("rst_ir", 32'(bus.ir), 32'h0);
        check("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);

        rst_n = 1'b1;
        tick();
        check("first_req_latency", 32'(bus.mem_req), 32'd1);

        // Zero-wait streaming: one instruction per two cycles.
        for (int i = 0; i < 8; i++) begin
            check("seq_mem_req", 32'(bus.mem_req), 32'd1);
            check("seq_mem_addr", 32'(bus.mem_addr), 32'(i));
            check("seq_ir_valid_low", 32'(bus.ir_valid), 32'd0);
            push(12'(i));
            tick();
            check("seq_ir_valid", 32'(bus.ir_valid), 32'd1);
            check("seq_ir_pc", 32'(bus.ir_pc), 32'(i));
            tick();
        end
        $display("[TB] sequential fetch 000..007 done");

        // Decode stall: IR held for five cycles, no new request.
        bus.ir_ready = 1'b0;
        push(12'h008);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_ir_valid", 32'(bus.ir_valid), 32'd1);
            check("stall_ir_pc", 32'(bus.ir_pc), 32'h008);
            check("stall_ir", 32'(bus.ir), 32'(instr(12'h008)));
            check("stall_mem_req", 32'(bus.mem_req), 32'd0);
            tick();
        end
        bus.ir_ready = 1'b1;
        tick();
        check("stall_resume_addr", 32'(bus.mem_addr), 32'h009);
        check("stall_resume_req", 32'(bus.mem_req), 32'd1);
        $display("[TB] stall transaction done");

        // Redirect while a delayed request is outstanding.
        ack_delay               = 3;
        bus.redirect_valid      = 1'b1;
        bus.redirect_target     = 12'h3A0;
        tick();
        bus.redirect_valid      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("redir_old_addr", 32'(bus.mem_addr), 32'h009);
            check("redir_req_held", 32'(bus.mem_req), 32'd1);
            check("redir_ir_valid", 32'(bus.ir_valid), 32'd0);
            tick();
        end
        check("redir_new_addr", 32'(bus.mem_addr), 32'h3A0);
        check("redir_new_req", 32'(bus.mem_req), 32'd1);
        check("redir_ir_valid_after", 32'(bus.ir_valid), 32'd0);
        ack_delay = 0;
        push(12'h3A0);
        tick();
        check("redir_ir_pc", 32'(bus.ir_pc), 32'h3A0);
        tick();
        $display("[TB] redirect to 3A0 done");

        // Halt raised with a request outstanding: that IR still delivered.
        check("halt_pre_addr", 32'(bus.mem_addr), 32'h3A1);
        bus.halt = 1'b1;
        push(12'h3A1);
        tick();
        check("halt_ir_valid", 32'(bus.ir_valid), 32'd1);
        check("halt_ir_pc", 32'(bus.ir_pc), 32'h3A1);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("halt_mem_req", 32'(bus.mem_req), 32'd0);
            check("halt_ir_valid_low", 32'(bus.ir_valid), 32'd0);
            tick();
        end
        bus.halt = 1'b0;
        tick();
        check("halt_resume_req", 32'(bus.mem_req), 32'd1);
        check("halt_resume_addr", 32'(bus.mem_addr), 32'h3A2);
        $display("[TB] halt transaction done");

        // Redirect in S_HOLD with simultaneous accept, then PC wrap FFF -> 000.
        push(12'h3A2);
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 12'hFFF;
        tick();
        bus.redirect_valid  = 1'b0;
        check("wrap_addr_fff", 32'(bus.mem_addr), 32'hFFF);
        push(12'hFFF);
        tick();
        check("wrap_ir_pc_fff", 32'(bus.ir_pc), 32'hFFF);
        tick();
        check("wrap_addr_000", 32'(bus.mem_addr), 32'h000);
        push(12'h000);
        tick();
        tick();
        check("wrap_addr_001", 32'(bus.mem_addr), 32'h001);
        bus.halt = 1'b1;
        push(12'h001);
        tick();
        tick();
        check("end_idle_req", 32'(bus.mem_req), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] redirect-in-hold and wrap done");

        // Asynchronous reset in the middle of an outstanding request.
        ack_delay = 3;
        bus.halt  = 1'b0;
        tick();
        check("prerst_req", 32'(bus.mem_req), 32'd1);
        check("prerst_addr", 32'(bus.mem_addr), 32'h002);
`ifdef FETCH_CNT_EN
        check("fetch_cnt", 32'(fetch_cnt), 32'(n_accepts));
        check("fetch_cnt_abs", 32'(fetch_cnt), 32'd15);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        check("midrst_mem_addr", 32'(bus.mem_addr), 32'h000);
        check("midrst_ir_valid", 32'(bus.ir_valid), 32'd0);
`ifdef FETCH_CNT_EN
        check("midrst_fetch_cnt", 32'(fetch_cnt), 32'd0);
`endif
        $display("[TB] mid-request reset done");

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
